// File: rtl/seg7_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared widths, scan state type and digit-extraction helper
//               for the 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int DIG_W      = 3;
    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 8;
    localparam int WORD_MAX_W = DIG_W * MAX_DIGITS;

    typedef enum logic [0:0] {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_t;

    // Pull digit i out of a packed word (callers zero-extend to WORD_MAX_W).
    function automatic logic [DIG_W-1:0] get_digit(input logic [WORD_MAX_W-1:0] word,
                                                   input logic [2:0]            i);
        return word[32'(i) * DIG_W +: DIG_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl_if
// Description : Valid/ready write channel carrying a packed display word.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    import seg7_pkg::*;

    logic                          wr_valid;
    logic                          wr_ready;
    logic [DIG_W*NUM_DIGITS-1:0]   wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface
`default_nettype wire

// File: rtl/seg7_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg7_slot_timer
// Description : Slot counter and digit index for the scan controller.
//               Exposes next-state values so the parent can register its
//               outputs aligned with the state change, plus a commit strobe
//               on the last enabled cycle of a frame and a registered
//               frame_start pulse on the first cycle of the next frame.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 50000,
    parameter int DEAD_CYC   = 500,
    parameter int IDX_W      = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    output scan_state_t           state_nxt,
    output logic [IDX_W-1:0]      idx_nxt,
    output logic                  commit,
    output logic                  frame_start
);

    localparam int              SC_W      = $clog2(SLOT_CYC);
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SLOT_CYC - 1);
    localparam logic [SC_W-1:0] DEAD_LAST = SC_W'(DEAD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [SC_W-1:0]  sc;
    logic [SC_W-1:0]  sc_nxt;
    logic [IDX_W-1:0] idx;
    scan_state_t      state;

    // Next slot position; everything holds while scanning is disabled.
    always_comb begin
        sc_nxt    = sc;
        idx_nxt   = idx;
        state_nxt = state;
        commit    = 1'b0;
        if (en) begin
            if (sc == SC_LAST) begin
                sc_nxt    = '0;
                state_nxt = DEAD;
                commit    = (idx == IDX_LAST);
                idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                sc_nxt = sc + 1'b1;
                if (sc == DEAD_LAST) begin
                    state_nxt = ON;
                end
            end
        end
    end

    // Slot state registers; frame_start marks the cycle entering digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc          <= '0;
            idx         <= '0;
            state       <= DEAD;
            frame_start <= 1'b0;
        end else begin
            sc          <= sc_nxt;
            idx         <= idx_nxt;
            state       <= state_nxt;
            frame_start <= commit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode
//               7-segment display. Holds a shadow/active word pair so a new
//               word only becomes visible at a frame boundary.
//               Optional macro SEG7_SCAN_BLINK_EN adds per-digit blinking
//               (blink_mask input, BLINK_FRAMES parameter).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYC     = 50000,
    parameter int DEAD_CYC     = 500
`ifdef SEG7_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  en,
    seg7_scan_ctrl_if.slave            wr,
`ifdef SEG7_SCAN_BLINK_EN
    input  wire logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [DIG_W-1:0]           dig_val,
    output logic [NUM_DIGITS-1:0]      dig_sel,
    output logic                       frame_start
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int WORD_W = DIG_W * NUM_DIGITS;

    logic [WORD_W-1:0]     shadow;
    logic [WORD_W-1:0]     active;
    logic [WORD_W-1:0]     active_nxt;
    logic                  pending;
    logic                  accept;
    scan_state_t           state_nxt;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  commit;
    logic [NUM_DIGITS-1:0] sel_nxt;

    seg7_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT_CYC   (SLOT_CYC),
        .DEAD_CYC   (DEAD_CYC),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .state_nxt   (state_nxt),
        .idx_nxt     (idx_nxt),
        .commit      (commit),
        .frame_start (frame_start)
    );

    assign accept      = wr.wr_valid & ~pending;
    assign wr.wr_ready = ~pending;

    // Accept into shadow when free; promote to active only at frame end.
    // accept and a committing pending are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (accept) begin
            shadow  <= wr.wr_data;
            pending <= 1'b1;
        end else if (commit && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

    assign active_nxt = (commit && pending) ? shadow : active;

`ifdef SEG7_SCAN_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [BF_W-1:0] blink_cnt;
    logic            blink_phase;

    // Flip the blink phase once every BLINK_FRAMES frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (commit) begin
            if (blink_cnt == BF_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

    // Digit enable for the upcoming cycle; only one digit lit during ON.
    always_comb begin
        sel_nxt = '1;
        if (state_nxt == ON) begin
`ifdef SEG7_SCAN_BLINK_EN
            if (!(blink_phase && blink_mask[idx_nxt])) begin
                sel_nxt[idx_nxt] = 1'b0;
            end
`else
            sel_nxt[idx_nxt] = 1'b0;
`endif
        end
    end

    // Output registers loaded with the values for the next slot position so
    // they change on the same edge as the slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel <= '1;
            dig_val <= '0;
        end else begin
            dig_sel <= en ? sel_nxt : '1;
            dig_val <= get_digit(WORD_MAX_W'(active_nxt), 3'(idx_nxt));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl with a frame-time
//               reference model (position = enabled cycles mod frame length).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * SLOT;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         en    = 1'b0;
    logic [2:0]   dig_val;
    logic [N-1:0] dig_sel;
    logic         frame_start;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) wr_if ();

`ifdef SEG7_SCAN_BLINK_EN
    logic [N-1:0] blink_mask = '0;
`endif

    seg7_scan_ctrl #(
        .NUM_DIGITS (N),
        .SLOT_CYC   (SLOT),
        .DEAD_CYC   (DEAD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr          (wr_if),
`ifdef SEG7_SCAN_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .dig_val     (dig_val),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int scan_t;
    int active[N];
    int shadow[N];
    bit pending;
    bit en_q;
    bit fs_exp;
    bit last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        scan_t   = 0;
        pending  = 1'b0;
        en_q     = 1'b0;
        fs_exp   = 1'b0;
        last_acc = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i] = 0;
            shadow[i] = 0;
        end
    endtask

    // One clock edge of the model using the inputs stable at that edge.
    task automatic model_edge();
        bit last;
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        last = en && ((scan_t % FRAME) == FRAME - 1);
        acc  = wr_if.wr_valid && !pending;
        if (last && pending) begin
            active  = shadow;
            pending = 1'b0;
        end
        if (acc) begin
            for (int i = 0; i < N; i++)
                shadow[i] = int'((wr_if.wr_data >> (3 * i)) & 12'h7);
            pending = 1'b1;
        end
        if (en) scan_t++;
        fs_exp   = last;
        en_q     = en;
        last_acc = acc;
    endtask

    task automatic check_outputs();
        logic [N-1:0] sel;
        int p, idx, sc;
        p   = scan_t % FRAME;
        idx = p / SLOT;
        sc  = p % SLOT;
        sel = '1;
        if (en_q && sc >= DEAD) sel[idx] = 1'b0;
        check("dig_sel",     32'(dig_sel),        32'(sel));
        check("dig_val",     32'(dig_val),        32'(active[idx]));
        check("frame_start", 32'(frame_start),    32'(fs_exp));
        check("wr_ready",    32'(wr_if.wr_ready), 32'(!pending));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset pulse in the middle of the low clock phase.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        model_reset();

        // Reset values
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs();
        repeat (2) step();
        rst_n = 1'b1;
        en    = 1'b1;

        // Plain scanning, frame_start cadence, dead time
        repeat (40) step();

        // Single write mid-frame
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 12'o7531;
        step();
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 12'o2222;
        repeat (70) step();

        // Valid held high across a commit with two different words
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 12'o1234;
        step();
        wr_if.wr_data  = 12'o6543;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step();
            if (last_acc) break;
        end
        wr_if.wr_valid = 1'b0;
        repeat (FRAME + 8) step();

        // Freeze during digit 2 ON at sc=5
        for (int k = 0; k < 2 * FRAME; k++) begin
            if ((scan_t % FRAME) == 2 * SLOT + 5) break;
            step();
        end
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (10) step();

        // Reset with a write pending
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 12'o7777;
        step();
        wr_if.wr_valid = 1'b0;
        repeat (3) step();
        pulse_reset();
        repeat (FRAME + 4) step();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            en             = ($urandom_range(0, 9) != 0);
            wr_if.wr_valid = ($urandom_range(0, 3) == 0);
            wr_if.wr_data  = 12'($urandom);
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- All digits share one 3-bit-to-7-segment decoder (values 0..7, active-low segments).
- The block holds NUM_DIGITS 3-bit values and drives the shared decoder input plus active-low digit enables, one digit per time slot.
- Each slot starts with a dead-time to prevent ghosting; updates go through a valid/ready handshake and are committed only at frame boundaries.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SLOT_CYC, 50000, clock cycles per digit slot (>= DEAD_CYC+1).
- DEAD_CYC, 500, cycles at slot start with all digits off (>= 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset; release synchronous to clk.
- en  in  1  scan enable; 0 = all digits off, timers held.
- wr_valid  in  1  new display word offered.
- wr_ready  out  1  shadow register free; a write is accepted when wr_valid & wr_ready.
- wr_data  in  3*NUM_DIGITS  packed digit values; digit i = wr_data[3*i+2:3*i].
- dig_val  out  3  value for the shared decoder input (registered).
- dig_sel  out  NUM_DIGITS  active-low one-hot digit enable (registered).
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.

Behaviour:
- Reset (async, rst_n=0):
  - dig_sel = all 1s, dig_val = 0, frame_start = 0, wr_ready = 1.
  - Active and shadow registers = 0, pending = 0.
  - Digit index = 0, slot counter = 0, state = DEAD.
- Reset asserted mid-slot or mid-handshake: everything returns to reset values immediately. A pending write is lost.
- State machine, per slot; slot counter sc counts 0..SLOT_CYC-1:
  - DEAD: sc < DEAD_CYC. dig_sel = all 1s. dig_val = active[idx], so the decoder settles before the digit lights. Go to ON when sc = DEAD_CYC-1.
  - ON: dig_sel[idx] = 0, all other bits 1. dig_val = active[idx].
  - At sc = SLOT_CYC-1: sc returns to 0, state goes to DEAD, and idx advances. When idx = NUM_DIGITS-1 it wraps to 0.
- Register timing: dig_sel and dig_val are registered. They change on the clock edge where the state or idx changes; there is no combinational path from inputs to outputs.
- frame_start: high for exactly the one cycle where idx = 0 and sc = 0, once per NUM_DIGITS*SLOT_CYC cycles. It does not pulse while en = 0.
- Write handshake:
  - wr_ready = ~pending.
  - On acceptance: shadow <= wr_data, pending <= 1, and wr_ready falls on the next cycle.
  - Commit occurs on the last cycle of the last slot (idx = NUM_DIGITS-1, sc = SLOT_CYC-1). If pending, then active <= shadow and pending <= 0. The new values show from the next frame_start, so a frame never mixes old and new digits.
  - Acceptance and commit on the same cycle: impossible, because wr_ready = 0 whenever pending = 1. A write accepted on the commit cycle while pending = 0 is stored in shadow and committed at the end of the following frame.
  - wr_data is ignored when it is not accepted.
- en = 0: dig_sel is forced to all 1s on the next cycle, and sc, idx and state freeze. The handshake still operates, but nothing is committed while frozen.
- en rising: scanning resumes from the frozen sc/idx/state.
- Width rules:
  - sc width = $clog2(SLOT_CYC).
  - idx width = $clog2(NUM_DIGITS), minimum 1.
  - Wrap comparisons are exact equality; no overflow past the limits.

Optional Feature:
- Macro: SEG7_SCAN_BLINK_EN.
- When defined:
  - Adds input blink_mask [NUM_DIGITS-1:0] and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles an internal blink phase every BLINK_FRAMES frame_start pulses.
  - While the phase is 1, digits with blink_mask[i] = 1 stay off (dig_sel[i] = 1) during their ON time; timing is otherwise unchanged.
  - Phase resets to 0.
- When undefined: no port, no counter; behaviour exactly as above.

Decomposition:
- Package seg7_pkg:
  - DIG_W = 3.
  - SEG_W = 7.
  - Enum scan_state_t {DEAD, ON}.
  - Function to extract digit i from a packed word.
- Sub-module seg7_slot_timer: slot counter plus digit index with wrap, en hold, frame_start and commit strobes.
- The top level holds the handshake, the shadow/active registers and the output registers.

Test Plan:
- Directed scenarios use NUM_DIGITS=4, SLOT_CYC=8, DEAD_CYC=2.
- Reset then en=1 -> dig_sel=1111 for 2 cycles, then 1110 for 6 cycles, then 1111, 1101, ...; frame_start pulses every 32 cycles; dig_val=0.
- Write 12'o7531 mid-frame -> wr_ready=0 next cycle; digits still show 0 until the next frame_start. Then slot 0 shows dig_val=1, slot 1 shows 3, slot 2 shows 5, slot 3 shows 7; wr_ready=1 again.
- wr_valid held high with two different words -> only the first is accepted before commit. The second is accepted the cycle after commit and displayed one frame later.
- en=0 during digit 2 ON at sc=5 -> dig_sel=1111 next cycle with sc/idx frozen. en=1 -> digit 2 lit for the remaining 2 cycles.
- rst_n pulsed low mid-slot with pending=1 -> outputs go to reset values immediately; after release the display shows 0s and wr_ready=1.
- With SEG7_SCAN_BLINK_EN, BLINK_FRAMES=2, blink_mask=0010 -> digit 1 lit in frames 0-1, off in frames 2-3, lit again in frames 4-5; other digits always lit.
